// File: rtl/enemy_pkg.sv
// enemy_pkg: shared constants, FSM states and interval helper for the enemy fire scheduler.
package enemy_pkg;

    localparam int NUM_EN        = 5;
    localparam int NUM_SLOTS     = 3;
    localparam int BASE_INTERVAL = 60;
    localparam int STEP          = 6;
    localparam int MIN_INTERVAL  = 12;
    localparam int PAUSE_FRAMES  = 90;

    localparam int EN_W    = $clog2(NUM_EN);
    localparam int SLOT_W  = 2;
    localparam int PAUSE_W = 7;
    localparam int IVL_W   = 8;

    typedef enum logic [1:0] {
        PAUSE,
        WAIT,
        ARB,
        ISSUE
    } state_t;

    // Frames between shots for a level; a ninth bit catches underflow so
    // high levels clamp to the floor instead of wrapping to a huge interval.
    function automatic logic [IVL_W-1:0] calc_ivl(input logic [3:0] lvl);
        logic [8:0] diff;
        diff = 9'(BASE_INTERVAL) - 9'(lvl) * 9'(STEP);
        return (diff[8] || diff[7:0] < 8'(MIN_INTERVAL)) ? 8'(MIN_INTERVAL) : diff[7:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
// Ports:
//   req  in  N   request mask
//   ptr  in  IW  starting search position (must be < N)
//   gnt  out N   one-hot grant
//   idx  out IW  index of granted request
//   any  out 1   at least one request present
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int p;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            p = (int'(ptr) + i) % N;
            if (!any && req[p]) begin
                gnt[p] = 1'b1;
                idx    = IW'(p);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_fire_sched.sv
// enemy_fire_sched: paces enemy missile launches, picking shooter (round-robin) and free slot.
// Ports:
//   pclk          in   pixel clock
//   rst           in   asynchronous active-low reset
//   vsync_in      in   vertical sync, rising edge is a frame tick
//   alive         in   per-enemy live flags
//   slot_busy     in   per-slot missile in flight
//   level_in      in   current level
//   level_change  in   one-cycle pulse on level up
//   fire_ack      in   addressed slot accepted the launch
//   fire_valid    out  launch request pending
//   fire_en       out  one-hot shooting enemy
//   fire_slot     out  target slot index
//   paused        out  grace period active
module enemy_fire_sched
    import enemy_pkg::*;
(
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 vsync_in,
    input  logic [NUM_EN-1:0]    alive,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic [3:0]           level_in,
    input  logic                 level_change,
    input  logic                 fire_ack,
    output logic                 fire_valid,
    output logic [NUM_EN-1:0]    fire_en,
    output logic [SLOT_W-1:0]    fire_slot,
    output logic                 paused
);

    state_t               state_q, state_d;
    logic                 vsync_q;
    logic [PAUSE_W-1:0]   pause_q, pause_d;
    logic [IVL_W-1:0]     ivl_q, ivl_d;
    logic [EN_W-1:0]      rr_q, rr_d;
    logic [EN_W-1:0]      gnt_idx_q, gnt_idx_d;
    logic                 fire_valid_q, fire_valid_d;
    logic [NUM_EN-1:0]    fire_en_q, fire_en_d;
    logic [SLOT_W-1:0]    fire_slot_q, fire_slot_d;

    logic                 tick;
    logic [NUM_EN-1:0]    en_gnt;
    logic [EN_W-1:0]      en_idx;
    logic                 en_any;
    logic [NUM_SLOTS-1:0] slot_gnt_unused;
    logic [SLOT_W-1:0]    slot_idx;
    logic                 slot_any;

    assign tick = vsync_in & ~vsync_q;

    rr_arbiter #(.N(NUM_EN), .IW(EN_W)) u_en_arb (
        .req (alive),
        .ptr (rr_q),
        .gnt (en_gnt),
        .idx (en_idx),
        .any (en_any)
    );

    // Pointer fixed at 0 turns the round-robin into a lowest-free-slot pick.
    rr_arbiter #(.N(NUM_SLOTS), .IW(SLOT_W)) u_slot_arb (
        .req (~slot_busy),
        .ptr ('0),
        .gnt (slot_gnt_unused),
        .idx (slot_idx),
        .any (slot_any)
    );

    always_comb begin
        state_d      = state_q;
        pause_d      = pause_q;
        ivl_d        = ivl_q;
        rr_d         = rr_q;
        gnt_idx_d    = gnt_idx_q;
        fire_valid_d = fire_valid_q;
        fire_en_d    = fire_en_q;
        fire_slot_d  = fire_slot_q;
        if (level_change) begin
            state_d      = PAUSE;
            pause_d      = PAUSE_W'(PAUSE_FRAMES);
            rr_d         = '0;
            fire_valid_d = 1'b0;
            fire_en_d    = '0;
        end else begin
            case (state_q)
                PAUSE: if (tick) begin
                    if (pause_q <= PAUSE_W'(1)) begin
                        state_d = WAIT;
                        pause_d = '0;
                        ivl_d   = calc_ivl(level_in);
                    end else begin
                        pause_d = pause_q - PAUSE_W'(1);
                    end
                end
                WAIT: if (tick) begin
                    if (ivl_q <= IVL_W'(1)) begin
                        state_d = ARB;
                        ivl_d   = '0;
                    end else begin
                        ivl_d = ivl_q - IVL_W'(1);
                    end
                end
                // With no shooter or no free slot the shot stays owed here.
                ARB: if (en_any && slot_any) begin
                    state_d      = ISSUE;
                    fire_valid_d = 1'b1;
                    fire_en_d    = en_gnt;
                    fire_slot_d  = slot_idx;
                    gnt_idx_d    = en_idx;
                end
                ISSUE: if (fire_ack) begin
                    state_d      = WAIT;
                    fire_valid_d = 1'b0;
                    fire_en_d    = '0;
                    ivl_d        = calc_ivl(level_in);
                    rr_d         = (gnt_idx_q == EN_W'(NUM_EN - 1)) ? '0 : gnt_idx_q + EN_W'(1);
                end
                default: state_d = PAUSE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q      <= PAUSE;
            vsync_q      <= 1'b0;
            pause_q      <= PAUSE_W'(PAUSE_FRAMES);
            ivl_q        <= '0;
            rr_q         <= '0;
            gnt_idx_q    <= '0;
            fire_valid_q <= 1'b0;
            fire_en_q    <= '0;
            fire_slot_q  <= '0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_in;
            pause_q      <= pause_d;
            ivl_q        <= ivl_d;
            rr_q         <= rr_d;
            gnt_idx_q    <= gnt_idx_d;
            fire_valid_q <= fire_valid_d;
            fire_en_q    <= fire_en_d;
            fire_slot_q  <= fire_slot_d;
        end
    end

    assign fire_valid = fire_valid_q;
    assign fire_en    = fire_en_q;
    assign fire_slot  = fire_slot_q;
    assign paused     = (state_q == PAUSE);

endmodule

// File: tb/tb_enemy_fire_sched.sv
// tb_enemy_fire_sched: directed self-checking bench for enemy_fire_sched.
module tb_enemy_fire_sched;

    logic       pclk = 1'b0;
    logic       rst;
    logic       vsync_in;
    logic [4:0] alive;
    logic [2:0] slot_busy;
    logic [3:0] level_in;
    logic       level_change;
    logic       fire_ack;
    logic       fire_valid;
    logic [4:0] fire_en;
    logic [1:0] fire_slot;
    logic       paused;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 pclk = ~pclk;

    enemy_fire_sched dut (
        .pclk         (pclk),
        .rst          (rst),
        .vsync_in     (vsync_in),
        .alive        (alive),
        .slot_busy    (slot_busy),
        .level_in     (level_in),
        .level_change (level_change),
        .fire_ack     (fire_ack),
        .fire_valid   (fire_valid),
        .fire_en      (fire_en),
        .fire_slot    (fire_slot),
        .paused       (paused)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        @(negedge pclk) vsync_in = 1'b1;
        repeat (2) @(negedge pclk);
        vsync_in = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic frames_until_unpaused(output int cnt);
        cnt = 0;
        while (paused && cnt < 300) begin
            frame();
            cnt++;
        end
    endtask

    task automatic frames_until_fire(output int cnt);
        cnt = 0;
        while (!fire_valid && cnt < 300) begin
            frame();
            cnt++;
        end
    endtask

    task automatic ack();
        @(negedge pclk) fire_ack = 1'b1;
        @(negedge pclk) fire_ack = 1'b0;
        check("ack_drop", fire_valid, 0);
    endtask

    logic [4:0] alt_en [3] = '{5'b00100, 5'b10000, 5'b00100};

    initial begin
        rst = 1'b0; vsync_in = 1'b0; alive = 5'b11111; slot_busy = 3'b000;
        level_in = 4'd0; level_change = 1'b0; fire_ack = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_valid", fire_valid, 0);
        check("rst_en", fire_en, 0);
        check("rst_slot", fire_slot, 0);
        check("rst_paused", paused, 1);
        @(negedge pclk) rst = 1'b1;

        frames_until_unpaused(n);
        check("pause_len", n, 90);
        frames_until_fire(n);
        check("first_ivl", n, 60);
        check("first_en", fire_en, 5'b00001);
        check("first_slot", fire_slot, 0);
        repeat (2) frame();
        check("hold_valid", fire_valid, 1);
        check("hold_en", fire_en, 5'b00001);
        ack();
        repeat (3) @(negedge pclk);
        @(negedge pclk) fire_ack = 1'b1;
        @(negedge pclk) fire_ack = 1'b0;

        for (int k = 1; k <= 5; k++) begin
            frames_until_fire(n);
            check("rr_ivl", n, 60);
            check("rr_en", fire_en, 5'b00001 << (k % 5));
            ack();
        end

        alive = 5'b10100; slot_busy = 3'b011;
        for (int k = 0; k < 3; k++) begin
            frames_until_fire(n);
            check("alt_ivl", n, 60);
            check("alt_en", fire_en, alt_en[k]);
            check("alt_slot", fire_slot, 2);
            ack();
        end

        slot_busy = 3'b111;
        repeat (60) frame();
        check("busy_hold", fire_valid, 0);
        repeat (10) @(negedge pclk);
        check("busy_hold2", fire_valid, 0);
        slot_busy = 3'b101;
        @(negedge pclk);
        check("free_fire", fire_valid, 1);
        check("free_en", fire_en, 5'b10000);
        check("free_slot", fire_slot, 1);

        alive = 5'b11111; slot_busy = 3'b000; level_in = 4'd9;
        ack();
        frames_until_fire(n);
        check("lvl9_ivl", n, 12);
        check("lvl9_en", fire_en, 5'b00001);
        level_in = 4'd4;
        ack();
        frames_until_fire(n);
        check("lvl4_ivl", n, 36);
        check("lvl4_en", fire_en, 5'b00010);

        @(negedge pclk) begin level_change = 1'b1; fire_ack = 1'b1; end
        @(negedge pclk) begin level_change = 1'b0; fire_ack = 1'b0; end
        check("lc_valid", fire_valid, 0);
        check("lc_en", fire_en, 0);
        check("lc_paused", paused, 1);
        slot_busy = 3'b011;
        frames_until_unpaused(n);
        check("lc_pause_len", n, 90);
        frames_until_fire(n);
        check("lc_ivl", n, 36);
        check("lc_en0", fire_en, 5'b00001);
        check("lc_slot", fire_slot, 2);

        @(negedge pclk);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", fire_valid, 0);
        check("arst_en", fire_en, 0);
        check("arst_slot", fire_slot, 0);
        check("arst_paused", paused, 1);

        #10;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_fire_sched.md
Name: enemy_fire_sched

Overview:
Schedules enemy missile launches for the five-enemy formation. Picks which live enemy fires next (round-robin) and which free enemy-missile slot carries the shot. Paces shots by a per-level frame interval and holds a fire-free grace period after every level change. Sits beside the enemy chain and drives the per-slot enemy missile movers that produce en1..en3 missile coordinates.

Parameters:
NUM_EN, 5, number of enemies (requesters)
NUM_SLOTS, 3, number of enemy missile slots
BASE_INTERVAL, 60, frames between shots at level 0
STEP, 6, frames removed from interval per level
MIN_INTERVAL, 12, lower clamp on interval (frames)
PAUSE_FRAMES, 90, grace frames after level change/reset

Ports:
pclk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
vsync_in  in  1  vertical sync from timing chain; rising edge = frame tick
alive  in  NUM_EN  per-enemy live flag (lives_1..lives_5)
slot_busy  in  NUM_SLOTS  slot i missile currently in flight
level_in  in  4  current level
level_change  in  1  one-cycle pulse on level up
fire_ack  in  1  addressed slot accepted the launch
fire_valid  out  1  launch request pending
fire_en  out  NUM_EN  one-hot shooting enemy, valid with fire_valid
fire_slot  out  2  target slot index, valid with fire_valid
paused  out  1  grace period active

Behaviour:
- Clock/reset: single domain pclk; rst asynchronous, active-low. In reset: fire_valid=0, fire_en=0, fire_slot=0, paused=1, state=PAUSE, pause counter=PAUSE_FRAMES, interval counter=0, rr pointer=0.
- Frame tick: vsync_in registered once; tick = vsync_in & ~vsync_q (one pclk cycle, 1-cycle latency after edge).
- Interval: ivl = BASE_INTERVAL - level_in*STEP, computed 8-bit unsigned with underflow detection; if result < MIN_INTERVAL or underflow, ivl = MIN_INTERVAL. Latched when WAIT is entered.
- States:
  PAUSE: paused=1; pause counter decrements on tick; at 0 and tick -> WAIT, interval counter loaded with ivl.
  WAIT: decrement interval counter on tick; reaching 0 -> ARB.
  ARB (one cycle): requester set = alive; free slot = lowest index with slot_busy=0. If alive==0 or all slots busy -> stay in ARB, re-evaluate every cycle (shot owed, not dropped). Else grant = first alive at or after rr pointer (wrapping NUM_EN-1 -> 0); register fire_en/fire_slot, fire_valid=1 -> ISSUE.
  ISSUE: fire_en/fire_slot/fire_valid held stable until fire_ack. Cycle of fire_ack: fire_valid=0, fire_en=0 next cycle, rr pointer = granted index + 1 (wrap), interval counter reloaded with ivl -> WAIT.
- level_change has priority over everything in any state: next cycle fire_valid=0, fire_en=0, pause counter=PAUSE_FRAMES, rr pointer=0 -> PAUSE. A pending ISSUE is abandoned; a fire_ack in the same cycle as level_change is ignored.
- Granted enemy dying during ISSUE: request still held (shot already committed).
- fire_ack while fire_valid=0: ignored.
- Tick in ARB/ISSUE: not counted.
- At most one launch per ivl frames; minimum of 2 pclk cycles between consecutive fire_valid assertions.

Decomposition:
- Shared package enemy_pkg: NUM_EN, NUM_SLOTS, state enum (PAUSE, WAIT, ARB, ISSUE), timing constants BASE_INTERVAL/STEP/MIN_INTERVAL/PAUSE_FRAMES.
- One sub-module rr_arbiter: combinational round-robin pick from request mask + pointer, outputs one-hot grant + index + any_grant; reused for slot picking later.

Test Plan:
- Reset release, alive=5'b11111, slots free, level 0 -> paused=1 for 90 ticks, then first fire_valid 60 ticks later with fire_en=5'b00001, fire_slot=0.
- Ack each shot immediately, slots free -> fire_en sequence 00001,00010,00100,01000,10000,00001; ticks between shots exactly 60.
- alive=5'b10100, slot_busy=3'b011 -> grants alternate 00100/10000, fire_slot=2 always; slot_busy=3'b111 -> stays in ARB, fire_valid=0 until a slot frees, then fires same cycle+1.
- level_in=9 -> interval clamps to 12 frames; level_in=4 -> 36 frames.
- level_change pulse while fire_valid=1 and fire_ack same cycle -> fire_valid drops next cycle, paused=1, rr pointer reset, next shot from enemy 0 after 90+ivl ticks.
- Assert rst low mid-ISSUE -> outputs return to reset values immediately, without waiting for a pclk edge.
